// File: rtl/ysyx_25040109_regfile_csr_if.sv
// Bus between the core datapath and the GPR/CSR storage block.
// master: decode/write-back/trap control (drives requests, sees read data)
// slave : ysyx_25040109_regfile_csr
// Signals: pc, GPR write (wen/waddr/wdata), GPR reads (raddr1/2 -> rdata1/2),
//          a0_out, CSR access (csr_op/csr_addr/csr_src -> csr_rdata/csr_illegal),
//          trap entry (trap_valid/trap_pc/trap_cause), mret_valid,
//          mepc_out/mtvec_out for PC select.
interface ysyx_25040109_regfile_csr_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned AW         = $clog2(NREGS)
);
  logic [31:0]         pc;
  logic                wen;
  logic [AW-1:0]       waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [AW-1:0]       raddr1;
  logic [AW-1:0]       raddr2;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [DATA_WIDTH-1:0] rdata2;
  logic [DATA_WIDTH-1:0] a0_out;
  logic [1:0]          csr_op;
  logic [11:0]         csr_addr;
  logic [31:0]         csr_src;
  logic [31:0]         csr_rdata;
  logic                csr_illegal;
  logic                trap_valid;
  logic [31:0]         trap_pc;
  logic [31:0]         trap_cause;
  logic                mret_valid;
  logic [31:0]         mepc_out;
  logic [31:0]         mtvec_out;

  modport master (
    output pc, wen, waddr, wdata, raddr1, raddr2,
    output csr_op, csr_addr, csr_src,
    output trap_valid, trap_pc, trap_cause, mret_valid,
    input  rdata1, rdata2, a0_out, csr_rdata, csr_illegal, mepc_out, mtvec_out
  );

  modport slave (
    input  pc, wen, waddr, wdata, raddr1, raddr2,
    input  csr_op, csr_addr, csr_src,
    input  trap_valid, trap_pc, trap_cause, mret_valid,
    output rdata1, rdata2, a0_out, csr_rdata, csr_illegal, mepc_out, mtvec_out
  );
endinterface

// File: rtl/ysyx_25040109_regfile_csr.sv
// Integer register file (RV32I 32 regs / RV32E 16 regs) plus M-mode CSR bank:
// mstatus, mtvec, mepc, mcause, mcycle/mcycleh, with CSR read-modify-write,
// atomic trap entry, mret restore and a free-running 64-bit cycle counter.
// Ports: clk, rst_n (async, active-low), bus (slave modport of
//        ysyx_25040109_regfile_csr_if carrying all request/response signals).
// Macros:
//   YSYX_RF_BYPASS_EN   - forward same-cycle write data to the GPR read ports.
module ysyx_25040109_regfile_csr #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NREGS      = 32
) (
  input  logic clk,
  input  logic rst_n,
  ysyx_25040109_regfile_csr_if.slave bus
);

  localparam int unsigned AW   = $clog2(NREGS);
  localparam int unsigned XLEN = 32;
  localparam logic [AW-1:0] X0 = AW'(0);
  localparam int unsigned A0_IDX = 10;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH = 12'hB80;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // ---------------------------------------------------------------- GPRs
  logic [DATA_WIDTH-1:0] gpr [NREGS];

  // GPR storage; x0 is never written and is forced to zero on read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        gpr[i] <= '0;
      end
    end else if (bus.wen && (bus.waddr != X0)) begin
      gpr[bus.waddr] <= bus.wdata;
    end
  end

  // Read ports
  always_comb begin
    bus.rdata1 = (bus.raddr1 == X0) ? '0 : gpr[bus.raddr1];
    bus.rdata2 = (bus.raddr2 == X0) ? '0 : gpr[bus.raddr2];
`ifdef YSYX_RF_BYPASS_EN
    // Write-through forwarding of the in-flight write-back value
    if (bus.wen && (bus.waddr == bus.raddr1) && (bus.raddr1 != X0)) begin
      bus.rdata1 = bus.wdata;
    end
    if (bus.wen && (bus.waddr == bus.raddr2) && (bus.raddr2 != X0)) begin
      bus.rdata2 = bus.wdata;
    end
`endif
  end

  assign bus.a0_out = gpr[A0_IDX];

  // ---------------------------------------------------------------- CSRs
  // Only the writable fields are stored; fixed fields are rebuilt on read.
  logic              mie_q;
  logic              mpie_q;
  logic [XLEN-1:2]   mtvec_q;
  logic [XLEN-1:2]   mepc_q;
  logic [XLEN-1:0]   mcause_q;
  logic [XLEN-1:0]   mcycle_lo_q;
  logic [XLEN-1:0]   mcycle_hi_q;

  logic [XLEN-1:0]   mstatus_val;
  logic [XLEN-1:0]   csr_old;
  logic              csr_hit;
  logic [XLEN-1:0]   csr_new;
  logic              csr_we;
  logic              wr_mcycle;
  logic              wr_mcycleh;

  // MPP is hard-wired to M-mode (11)
  assign mstatus_val = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};

  // CSR address decode and old-value read
  always_comb begin
    csr_old = '0;
    csr_hit = 1'b1;
    case (bus.csr_addr)
      CSR_MSTATUS: csr_old = mstatus_val;
      CSR_MTVEC:   csr_old = {mtvec_q, 2'b00};
      CSR_MEPC:    csr_old = {mepc_q, 2'b00};
      CSR_MCAUSE:  csr_old = mcause_q;
      CSR_MCYCLE:  csr_old = mcycle_lo_q;
      CSR_MCYCLEH: csr_old = mcycle_hi_q;
      default:     csr_hit = 1'b0;
    endcase
  end

  assign bus.csr_rdata   = csr_old;
  assign bus.csr_illegal = ~csr_hit;
  assign bus.mepc_out    = {mepc_q, 2'b00};
  assign bus.mtvec_out   = {mtvec_q, 2'b00};

  // Read-modify-write value
  always_comb begin
    csr_new = csr_old;
    case (bus.csr_op)
      OP_WRITE: csr_new = bus.csr_src;
      OP_SET:   csr_new = csr_old | bus.csr_src;
      OP_CLEAR: csr_new = csr_old & ~bus.csr_src;
      default:  csr_new = csr_old;
    endcase
  end

  // Trap and mret pre-empt any CSR instruction update in the same cycle
  assign csr_we     = (bus.csr_op != 2'b00) && csr_hit && !bus.trap_valid && !bus.mret_valid;
  assign wr_mcycle  = csr_we && (bus.csr_addr == CSR_MCYCLE);
  assign wr_mcycleh = csr_we && (bus.csr_addr == CSR_MCYCLEH);

  // mstatus / mtvec / mepc / mcause update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtvec_q  <= '0;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else if (bus.trap_valid) begin
      mepc_q   <= bus.trap_pc[XLEN-1:2];
      mcause_q <= bus.trap_cause;
      mpie_q   <= mie_q;
      mie_q    <= 1'b0;
    end else if (bus.mret_valid) begin
      mie_q    <= mpie_q;
      mpie_q   <= 1'b1;
    end else if (csr_we) begin
      case (bus.csr_addr)
        CSR_MSTATUS: begin
          mie_q  <= csr_new[3];
          mpie_q <= csr_new[7];
        end
        CSR_MTVEC:  mtvec_q  <= csr_new[XLEN-1:2];
        CSR_MEPC:   mepc_q   <= csr_new[XLEN-1:2];
        CSR_MCAUSE: mcause_q <= csr_new;
        default: ;
      endcase
    end
  end

  // 64-bit cycle counter; a written half takes the write value instead of
  // counting, and a written low half produces no carry that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_lo_q <= '0;
      mcycle_hi_q <= '0;
    end else begin
      if (wr_mcycle) begin
        mcycle_lo_q <= csr_new;
      end else begin
        mcycle_lo_q <= mcycle_lo_q + 32'd1;
      end
      if (wr_mcycleh) begin
        mcycle_hi_q <= csr_new;
      end else if (!wr_mcycle && (mcycle_lo_q == 32'hFFFF_FFFF)) begin
        mcycle_hi_q <= mcycle_hi_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25040109_regfile_csr.sv
// Scoreboard bench: stimulus process drives one request per cycle and pushes
// the reference-model expectation; a monitor pops and compares on negedge.
module tb_ysyx_25040109_regfile_csr;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_25040109_regfile_csr_if #(.DATA_WIDTH(32), .NREGS(32)) bus ();

  ysyx_25040109_regfile_csr #(.DATA_WIDTH(32), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [1:0]  op;
    logic [11:0] caddr;
    logic [31:0] csrc;
    logic        trap;
    logic [31:0] tpc;
    logic [31:0] tcause;
    logic        mret;
    logic [31:0] pc;
  } stim_t;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] a0;
    logic [31:0] crd;
    logic        ill;
    logic [31:0] mepc;
    logic [31:0] mtvec;
    logic        kc_en;
    logic [31:0] kc;
    logic        kr_en;
    logic [31:0] kr;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // ---------------- reference model: architectural state as plain variables
  logic [31:0] m_gpr [32];
  logic        m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mepc, m_mcause;
  logic [63:0] m_cyc;
  stim_t       prev;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
    m_mie = 1'b0; m_mpie = 1'b0;
    m_mtvec = 32'd0; m_mepc = 32'd0; m_mcause = 32'd0;
    m_cyc = 64'd0;
  endtask

  function automatic logic [31:0] m_read_csr(input logic [11:0] a, output logic hit);
    hit = 1'b1;
    case (a)
      12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      default: begin hit = 1'b0; return 32'd0; end
    endcase
  endfunction

  // Effect of one clock edge with inputs s
  task automatic model_apply(input stim_t s);
    logic hit;
    logic [31:0] old, nv;
    logic applies;
    old = m_read_csr(s.caddr, hit);
    case (s.op)
      2'b01:   nv = s.csrc;
      2'b10:   nv = old | s.csrc;
      2'b11:   nv = old & ~s.csrc;
      default: nv = old;
    endcase
    applies = (s.op != 2'b00) && hit && !s.trap && !s.mret;
    if (applies && s.caddr == 12'hB00)      m_cyc = {m_cyc[63:32], nv};
    else if (applies && s.caddr == 12'hB80) m_cyc = {nv, m_cyc[31:0] + 32'd1};
    else                                    m_cyc = m_cyc + 64'd1;
    if (s.wen && s.waddr != 5'd0) m_gpr[s.waddr] = s.wdata;
    if (s.trap) begin
      m_mepc = s.tpc & ~32'd3;
      m_mcause = s.tcause;
      m_mpie = m_mie;
      m_mie = 1'b0;
    end else if (s.mret) begin
      m_mie = m_mpie;
      m_mpie = 1'b1;
    end else if (applies) begin
      case (s.caddr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h305: m_mtvec = nv & ~32'd3;
        12'h341: m_mepc = nv & ~32'd3;
        12'h342: m_mcause = nv;
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] m_gpr_read(input stim_t s, input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : m_gpr[a];
`ifdef YSYX_RF_BYPASS_EN
    if (s.wen && s.waddr == a && a != 5'd0) v = s.wdata;
`endif
    return v;
  endfunction

  function automatic exp_t model_expect(input stim_t s);
    exp_t e;
    logic hit;
    e = '0;
    e.r1 = m_gpr_read(s, s.raddr1);
    e.r2 = m_gpr_read(s, s.raddr2);
    e.a0 = m_gpr[10];
    e.crd = m_read_csr(s.caddr, hit);
    e.ill = ~hit;
    e.mepc = m_mepc;
    e.mtvec = m_mtvec;
    return e;
  endfunction

  // ---------------- stimulus helpers
  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] src);
    stim_t s;
    s = idle();
    s.op = op; s.caddr = a; s.csrc = src;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    logic [11:0] addrs [7];
    addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h341; addrs[3] = 12'h342;
    addrs[4] = 12'hB00; addrs[5] = 12'hB80; addrs[6] = 12'($urandom);
    s.wen    = 1'($urandom);
    s.waddr  = 5'($urandom);
    s.wdata  = $urandom;
    s.raddr1 = ($urandom_range(0, 3) == 0) ? s.waddr : 5'($urandom);
    s.raddr2 = 5'($urandom);
    s.op     = 2'($urandom);
    s.caddr  = addrs[$urandom_range(0, 6)];
    s.csrc   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
    s.trap   = ($urandom_range(0, 9) == 0);
    s.tpc    = $urandom;
    s.tcause = $urandom;
    s.mret   = ($urandom_range(0, 9) == 0);
    s.pc     = $urandom;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.wen = s.wen; bus.waddr = s.waddr; bus.wdata = s.wdata;
    bus.raddr1 = s.raddr1; bus.raddr2 = s.raddr2;
    bus.csr_op = s.op; bus.csr_addr = s.caddr; bus.csr_src = s.csrc;
    bus.trap_valid = s.trap; bus.trap_pc = s.tpc; bus.trap_cause = s.tcause;
    bus.mret_valid = s.mret; bus.pc = s.pc;
  endtask

  // One cycle: account for the edge just taken, present s, queue expectation.
  // Optional constants kc/kr pin csr_rdata / rdata1 to hand-derived values.
  task automatic step(input stim_t s, input bit kc_en, input logic [31:0] kc,
                      input bit kr_en, input logic [31:0] kr);
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst_n) rst_n = 1'b1;
    else        model_apply(prev);
    prev = s;
    drive(s);
    e = model_expect(s);
    e.kc_en = kc_en; e.kc = kc; e.kr_en = kr_en; e.kr = kr;
    q.push_back(e);
  endtask

  // Asynchronous reset between edges, checked before any edge can occur
  task automatic async_reset();
    stim_t s;
    exp_t e;
    @(posedge clk);
    #1;
    model_apply(prev);
    #2;
    rst_n = 1'b0;
    model_reset();
    s = idle(); s.caddr = 12'hB00; s.raddr1 = 5'd5;
    prev = s;
    drive(s);
    e = model_expect(s);
    e.kc_en = 1'b1; e.kc = 32'd0; e.kr_en = 1'b1; e.kr = 32'd0;
    q.push_back(e);
    @(posedge clk);
    #1;
    s = idle(); s.caddr = 12'h300;
    prev = s;
    drive(s);
    e = model_expect(s);
    e.kc_en = 1'b1; e.kc = 32'h1800;
    q.push_back(e);
  endtask

  // ---------------- monitor
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rdata1", bus.rdata1, e.r1);
        chk("rdata2", bus.rdata2, e.r2);
        chk("a0_out", bus.a0_out, e.a0);
        chk("csr_rdata", bus.csr_rdata, e.crd);
        chk("csr_illegal", 32'(bus.csr_illegal), 32'(e.ill));
        chk("mepc_out", bus.mepc_out, e.mepc);
        chk("mtvec_out", bus.mtvec_out, e.mtvec);
        if (e.kc_en) chk("csr_rdata_const", bus.csr_rdata, e.kc);
        if (e.kr_en) chk("rdata1_const", bus.rdata1, e.kr);
      end
    end
  end

  // ---------------- stimulus
  initial begin
    stim_t s;
    rst_n = 1'b0;
    prev = idle();
    drive(prev);
    model_reset();
    repeat (3) @(posedge clk);

    // counter starts at 0 then 1 after reset release
    step(csr(2'b00, 12'hB00, 32'd0), 1, 32'd0, 0, 0);
    step(csr(2'b00, 12'hB00, 32'd0), 1, 32'd1, 0, 0);

    // GPR writes, x0 immutable, same-cycle read of x31
    s = idle(); s.wen = 1; s.waddr = 5'd0; s.wdata = 32'hFFFF; s.raddr1 = 5'd0;
    step(s, 0, 0, 1, 32'd0);
    s = idle(); s.wen = 1; s.waddr = 5'd31; s.wdata = 32'hDEADBEEF; s.raddr1 = 5'd31;
`ifdef YSYX_RF_BYPASS_EN
    step(s, 0, 0, 1, 32'hDEADBEEF);
`else
    step(s, 0, 0, 1, 32'd0);
`endif
    s = idle(); s.raddr1 = 5'd31;
    step(s, 0, 0, 1, 32'hDEADBEEF);
    s = idle(); s.raddr1 = 5'd0;
    step(s, 0, 0, 1, 32'd0);

    // CSR read-modify-write and WARL
    step(csr(2'b01, 12'h305, 32'h80000103), 0, 0, 0, 0);
    step(csr(2'b00, 12'h305, 32'd0), 1, 32'h80000100, 0, 0);
    step(csr(2'b10, 12'h300, 32'h8), 0, 0, 0, 0);
    step(csr(2'b00, 12'h300, 32'd0), 1, 32'h1808, 0, 0);
    step(csr(2'b10, 12'h300, 32'd0), 1, 32'h1808, 0, 0);
    step(csr(2'b11, 12'h300, 32'h8), 0, 0, 0, 0);
    step(csr(2'b00, 12'h300, 32'd0), 1, 32'h1800, 0, 0);
    step(csr(2'b01, 12'h7C0, 32'hFFFF), 1, 32'd0, 0, 0);

    // Trap entry then mret
    step(csr(2'b10, 12'h300, 32'h8), 0, 0, 0, 0);
    s = idle(); s.trap = 1; s.tpc = 32'h80000010; s.tcause = 32'd11;
    step(s, 0, 0, 0, 0);
    step(csr(2'b00, 12'h341, 32'd0), 1, 32'h80000010, 0, 0);
    step(csr(2'b00, 12'h342, 32'd0), 1, 32'd11, 0, 0);
    step(csr(2'b00, 12'h300, 32'd0), 1, 32'h1880, 0, 0);
    s = idle(); s.mret = 1;
    step(s, 0, 0, 0, 0);
    step(csr(2'b00, 12'h300, 32'd0), 1, 32'h1888, 0, 0);

    // Trap beats a same-cycle CSR write to mepc
    s = csr(2'b01, 12'h341, 32'h5); s.trap = 1; s.tpc = 32'h80000022; s.tcause = 32'd7;
    step(s, 0, 0, 0, 0);
    step(csr(2'b00, 12'h341, 32'd0), 1, 32'h80000020, 0, 0);

    // Counter carry from low into high word
    step(csr(2'b01, 12'hB80, 32'd0), 0, 0, 0, 0);
    step(csr(2'b01, 12'hB00, 32'hFFFFFFFF), 0, 0, 0, 0);
    step(csr(2'b00, 12'hB00, 32'd0), 1, 32'hFFFFFFFF, 0, 0);
    step(csr(2'b00, 12'hB00, 32'd0), 1, 32'd0, 0, 0);
    step(csr(2'b00, 12'hB80, 32'd0), 1, 32'd1, 0, 0);

    // Mid-run asynchronous reset with live state
    s = idle(); s.wen = 1; s.waddr = 5'd5; s.wdata = 32'h1234;
    step(s, 0, 0, 0, 0);
    s = idle(); s.raddr1 = 5'd5;
    step(s, 0, 0, 1, 32'h1234);
    async_reset();
    step(csr(2'b00, 12'hB00, 32'd0), 1, 32'd0, 0, 0);

    // Randomized traffic with one more reset in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 300) async_reset();
      step(rand_stim(), 0, 0, 0, 0);
    end
    step(idle(), 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d required=0 pending entries", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
